regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the core's single-write register file. It provides NRD read ports and two write-back ports, optional write-to-read bypass, and a per-register busy scoreboard. The issue stage reserves destination registers. Write-back clears them. The block raises a stall whenever an enabled read port addresses a register with a result still outstanding. Register 0 is hardwired to zero and never busy.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
localparam AW = $clog2(NREGS), address width
localparam CW = $clog2(NREGS)+1, busy count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  NRD  per-port read valid (qualifies stall only)
rd_addr  input  NRD*AW  port i address at [i*AW +: AW]
rd_data  output  NRD*XLEN  port i data at [i*XLEN +: XLEN]
rd_busy  output  NRD  port i operand not yet available
stall  output  1  OR over i of (rd_en[i] & rd_busy[i])
wb0_en  input  1  write port 0 enable
wb0_addr  input  AW  write port 0 address
wb0_data  input  XLEN  write port 0 data
wb1_en  input  1  write port 1 enable (younger, higher priority)
wb1_addr  input  AW  write port 1 address
wb1_data  input  XLEN  write port 1 data
rsv_en  input  1  reserve destination (set busy)
rsv_addr  input  AW  register to reserve
busy_cnt  output  CW  number of registers currently busy

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, busy_cnt = 0. Outputs: rd_data = 0 for address 0, else 0 (storage cleared). rd_busy = 0, stall = 0.
- Writes are committed on the rising clk edge. An address of 0 is ignored on every write and reserve port.
- wb0 and wb1 to the same nonzero address in the same cycle: the wb1 data is stored, and a single busy clear occurs.
- Read is combinational. Address 0 returns 0.
- BYPASS=1: if wb1_en hits the read address, the read returns wb1_data. Else, if wb0_en hits, it returns wb0_data. Else it returns the stored value.
- BYPASS=0: the read always returns the stored value, so written data becomes visible the cycle after the edge.
- Scoreboard busy[r] next state, evaluated per register:
  - If rsv_en and rsv_addr == r and r != 0: set to 1. Reserve wins over a simultaneous write-back to the same register, because the reservation belongs to a newer producer.
  - Else, if any wbN_en hits r: clear to 0.
  - Else: hold.
- A write-back to a non-busy register still writes the data. The busy bit stays 0.
- rd_busy[i] = busy[addr_i] & ~(BYPASS & (write-back hitting addr_i this cycle)). It is 0 for address 0.
  - A same-cycle reservation does not affect rd_busy; it shows from the next cycle.
- stall is combinational from rd_en, rd_addr, the busy bits and the wb inputs. There is no registered latency.
- busy_cnt is registered. Next value = popcount(next busy). It stays consistent at all times and never exceeds NREGS-1.
- Reset asserted mid-operation clears all state immediately. The first edge after rst deasserts behaves as the first cycle after reset.

Test Plan:
- Reset, then read all ports at addresses 0..NREGS-1 -> all rd_data = 0, rd_busy = 0, stall = 0, busy_cnt = 0.
- wb0 writes 0xDEADBEEF to x5 with BYPASS=1 and rd_addr0 = 5 in the same cycle -> rd_data0 = 0xDEADBEEF in that cycle. The same value persists after the write is deasserted. With BYPASS=0, the same-cycle read is 0 and the next cycle reads 0xDEADBEEF.
- Write 0x1234 to x0 via wb1, and reserve x0 -> rd_data for x0 = 0, busy_cnt stays 0.
- wb0 = (x7, 0x11) and wb1 = (x7, 0x22) in the same cycle -> x7 reads 0x22 both bypassed and stored.
- Reserve x3, then assert rd_en0 with rd_addr0 = 3 -> next cycle rd_busy0 = 1, stall = 1, busy_cnt = 1. Then wb0 writes (x3, 0xA5) -> in that cycle (BYPASS=1) stall = 0 and rd_data0 = 0xA5. Next cycle busy_cnt = 0.
- Same cycle as x3 is busy: rsv x3 plus wb0 x3 = 0x55 -> x3 stores 0x55 but stays busy, and busy_cnt stays 1. Asserting rst mid-sequence -> busy_cnt = 0 and x3 = 0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with two write-back ports, optional write-to-read
// bypass and a per-register busy scoreboard that drives the issue-stage stall.

module regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_q,
  input  logic            i_busy,
  input  logic            i_wb0_en,
  input  logic [AW-1:0]   i_wb0_addr,
  input  logic [XLEN-1:0] i_wb0_data,
  input  logic            i_wb1_en,
  input  logic [AW-1:0]   i_wb1_addr,
  input  logic [XLEN-1:0] i_wb1_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);
  logic w_nz, w_hit0, w_hit1;

  assign w_nz   = |i_addr;
  assign w_hit0 = (BYPASS != 0) && w_nz && i_wb0_en && (i_wb0_addr == i_addr);
  assign w_hit1 = (BYPASS != 0) && w_nz && i_wb1_en && (i_wb1_addr == i_addr);

  // wb1 is the younger producer, so it takes precedence on the bypass path
  always_comb begin
    o_data = i_q;
    if (!w_nz)       o_data = '0;
    else if (w_hit1) o_data = i_wb1_data;
    else if (w_hit0) o_data = i_wb0_data;
  end

  assign o_busy = w_nz & i_busy & ~(w_hit0 | w_hit1);
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic                stall,
  input  logic                wb0_en,
  input  logic [AW-1:0]       wb0_addr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_en,
  input  logic [AW-1:0]       wb1_addr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [CW-1:0]       busy_cnt
);
  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_busy;
  logic [CW-1:0]              r_busy_cnt;

  logic [NREGS-1:0] w_wb0_hit, w_wb1_hit, w_rsv_hit, w_busy_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Register 0 never matches, so it is never written, reserved or busy
  always_comb begin
    w_wb0_hit  = '0;
    w_wb1_hit  = '0;
    w_rsv_hit  = '0;
    w_busy_nxt = '0;
    w_cnt_nxt  = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_wb0_hit[r] = wb0_en && (wb0_addr == AW'(r));
      w_wb1_hit[r] = wb1_en && (wb1_addr == AW'(r));
      w_rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
      // A reservation belongs to a newer producer than any completing write-back
      if (w_rsv_hit[r])                     w_busy_nxt[r] = 1'b1;
      else if (w_wb0_hit[r] | w_wb1_hit[r]) w_busy_nxt[r] = 1'b0;
      else                                  w_busy_nxt[r] = r_busy[r];
    end
    for (int r = 0; r < NREGS; r++)
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs     <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_wb1_hit[r])      r_regs[r] <= wb1_data;
        else if (w_wb0_hit[r]) r_regs[r] <= wb0_data;
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr[i*AW +: AW];
      regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
        .i_addr     (w_addr),
        .i_q        (r_regs[w_addr]),
        .i_busy     (r_busy[w_addr]),
        .i_wb0_en   (wb0_en),
        .i_wb0_addr (wb0_addr),
        .i_wb0_data (wb0_data),
        .i_wb1_en   (wb1_en),
        .i_wb1_addr (wb1_addr),
        .i_wb1_data (wb1_data),
        .o_data     (rd_data[i*XLEN +: XLEN]),
        .o_busy     (rd_busy[i])
      );
    end
  endgenerate

  assign stall    = |(rd_en & rd_busy);
  assign busy_cnt = r_busy_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing instance share stimulus,
// each output compared against hand-computed values.

module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5, CW = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic                wb0_en, wb1_en, rsv_en;
  logic [AW-1:0]       wb0_addr, wb1_addr, rsv_addr;
  logic [XLEN-1:0]     wb0_data, wb1_data;

  logic [NRD*XLEN-1:0] a_data, b_data;
  logic [NRD-1:0]      a_busy, b_busy;
  logic                a_stall, b_stall;
  logic [CW-1:0]       a_cnt, b_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_data), .rd_busy(a_busy), .stall(a_stall),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(a_cnt)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_data), .rd_busy(b_busy), .stall(b_stall),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    wb0_en = 1'b0; wb1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    rd_addr = {a1, a0};
    rd_en   = en;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wb0_addr = '0; wb1_addr = '0; rsv_addr = '0;
    wb0_data = '0; wb1_data = '0;
    rd(0, 0, 2'b00);
    #2;
    chk("rst_cnt_a", a_cnt, 0);
    chk("rst_cnt_b", b_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // all addresses read zero, nothing busy
    for (int a = 0; a < NREGS; a++) begin
      rd(AW'(a), AW'(NREGS - 1 - a), 2'b11);
      #1;
      chk($sformatf("rst_rd_a%0d", a), {a_data, a_busy, a_stall}, 0);
      chk($sformatf("rst_rd_b%0d", a), {b_data, b_busy, b_stall}, 0);
    end

    // x5 write: bypass visible same cycle, stored visible next cycle
    rd(5, 0, 2'b00);
    wb0_en = 1'b1; wb0_addr = 5; wb0_data = 32'hDEADBEEF;
    #1;
    chk("x5_byp_same", a_data[31:0], 32'hDEADBEEF);
    chk("x5_nobyp_same", b_data[31:0], 0);
    tick(); idle();
    #1;
    chk("x5_byp_next", a_data[31:0], 32'hDEADBEEF);
    chk("x5_nobyp_next", b_data[31:0], 32'hDEADBEEF);

    // x0 ignores writes and reservations
    rd(0, 0, 2'b11);
    wb1_en = 1'b1; wb1_addr = 0; wb1_data = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 0;
    #1;
    chk("x0_same_a", {a_data[31:0], a_busy[0]}, 0);
    chk("x0_same_b", b_data[31:0], 0);
    tick(); idle();
    #1;
    chk("x0_next_a", {a_data[31:0], a_busy, a_stall}, 0);
    chk("x0_cnt_a", a_cnt, 0);
    chk("x0_cnt_b", b_cnt, 0);

    // dual write to x7: wb1 wins
    rd(7, 0, 2'b00);
    wb0_en = 1'b1; wb0_addr = 7; wb0_data = 32'h11;
    wb1_en = 1'b1; wb1_addr = 7; wb1_data = 32'h22;
    #1;
    chk("x7_byp_same", a_data[31:0], 32'h22);
    chk("x7_nobyp_same", b_data[31:0], 0);
    tick(); idle();
    #1;
    chk("x7_byp_stored", a_data[31:0], 32'h22);
    chk("x7_nobyp_stored", b_data[31:0], 32'h22);

    // reserve x3: busy shows only from next cycle
    rd(3, 0, 2'b01);
    rsv_en = 1'b1; rsv_addr = 3;
    #1;
    chk("x3_rsv_same_busy", a_busy[0], 0);
    chk("x3_rsv_same_stall", a_stall, 0);
    tick(); idle();
    #1;
    chk("x3_busy_a", {a_busy[0], a_stall}, 2'b11);
    chk("x3_busy_b", {b_busy[0], b_stall}, 2'b11);
    chk("x3_cnt_a", a_cnt, 1);
    chk("x3_cnt_b", b_cnt, 1);

    // write-back to x3 releases the stall at once only with bypass
    wb0_en = 1'b1; wb0_addr = 3; wb0_data = 32'hA5;
    #1;
    chk("x3_wb_a", {a_data[31:0], a_busy[0], a_stall}, {32'hA5, 2'b00});
    chk("x3_wb_b", {b_data[31:0], b_busy[0], b_stall}, {32'h0, 2'b11});
    tick(); idle();
    #1;
    chk("x3_clr_cnt_a", a_cnt, 0);
    chk("x3_clr_cnt_b", b_cnt, 0);
    chk("x3_clr_b", {b_data[31:0], b_busy[0], b_stall}, {32'hA5, 2'b00});

    // reserve wins over simultaneous write-back
    rsv_en = 1'b1; rsv_addr = 3;
    tick(); idle();
    #1;
    chk("x3_rerv_cnt", a_cnt, 1);
    rsv_en = 1'b1; rsv_addr = 3;
    wb0_en = 1'b1; wb0_addr = 3; wb0_data = 32'h55;
    #1;
    chk("x3_rsvwb_same_a", {a_data[31:0], a_stall}, {32'h55, 1'b0});
    chk("x3_rsvwb_same_b", b_stall, 1);
    tick(); idle();
    #1;
    chk("x3_rsvwb_a", {a_data[31:0], a_busy[0], a_stall}, {32'h55, 2'b11});
    chk("x3_rsvwb_cnt_a", a_cnt, 1);
    chk("x3_rsvwb_cnt_b", b_cnt, 1);

    // second busy register; dual write-back gives a single clear
    rd(3, 9, 2'b10);
    rsv_en = 1'b1; rsv_addr = 9;
    tick(); idle();
    #1;
    chk("x9_busy_a", {a_busy, a_stall}, 3'b111);
    chk("x9_cnt_a", a_cnt, 2);
    wb0_en = 1'b1; wb0_addr = 9; wb0_data = 32'h90;
    wb1_en = 1'b1; wb1_addr = 9; wb1_data = 32'h91;
    #1;
    chk("x9_wb_a", {a_data[63:32], a_busy, a_stall}, {32'h91, 3'b010});
    chk("x9_wb_b", {b_busy, b_stall}, 3'b111);
    tick(); idle();
    #1;
    chk("x9_clr_cnt_a", a_cnt, 1);
    chk("x9_clr_cnt_b", b_cnt, 1);
    chk("x9_stored_b", {b_data[63:32], b_busy, b_stall}, {32'h91, 3'b010});

    // asynchronous reset mid-sequence
    rd(3, 9, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_a", {a_data, a_busy, a_stall, a_cnt}, 0);
    chk("mid_rst_b", {b_data, b_busy, b_stall, b_cnt}, 0);
    tick();
    rst = 1'b0;
    rsv_en = 1'b1; rsv_addr = 4;
    wb0_en = 1'b1; wb0_addr = 3; wb0_data = 32'h77;
    tick(); idle();
    rd(3, 4, 2'b11);
    #1;
    chk("post_rst_a", {a_data[31:0], a_busy, a_stall, a_cnt}, {32'h77, 2'b10, 1'b1, 6'd1});
    chk("post_rst_b", {b_data[31:0], b_busy, b_stall, b_cnt}, {32'h77, 2'b10, 1'b1, 6'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
